// File: rtl/scc_run_monitor.sv
// rtl/scc_run_monitor.sv - SCC run controller: reset sequencing, stop detection and bus traffic counters.
// Snoops the core's instruction and data buses; stops on halt store, self-loop fetch or cycle timeout.
module scc_run_monitor #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 16,
  parameter int                MAX_CYCLES  = 29,
  parameter int                RESET_HOLD  = 2,
  parameter logic [ADDR_W-1:0] HALT_ADDR   = 32'hFFFF_FFFC,
  parameter int                STALL_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_s,
  input  logic              start,
  input  logic              in_mem_en,
  input  logic [ADDR_W-1:0] in_mem_addr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_read,
  input  logic              data_write,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int REP_W  = $clog2(STALL_LIMIT + 1);

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_HALT = 2'b01;
  localparam logic [1:0] ST_LOOP = 2'b10;
  localparam logic [1:0] ST_TIME = 2'b11;

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [ADDR_W-1:0]   last_addr;
  logic                last_valid;
  logic [REP_W-1:0]    rep;
  logic [CNT_W-1:0]    cycle_next;
  logic [1:0]          status_next;
  logic                halt_hit;
  logic                repeat_fetch;
  logic                loop_hit;
  logic                time_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Outputs decode only the state register, so no input reaches them combinationally.
  assign core_reset = (state != RUN);
  assign running    = (state == RUN);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset_s) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    status_next  = ST_NONE;
    cycle_next   = cycle_count + 1'b1;
    halt_hit     = data_write && (data_addr == HALT_ADDR);
    repeat_fetch = in_mem_en && last_valid && (in_mem_addr == last_addr);
    loop_hit     = repeat_fetch && (rep == REP_W'(STALL_LIMIT - 1));
    time_hit     = (cycle_next == CNT_W'(MAX_CYCLES));
    case (state)
      IDLE: if (start) state_next = HOLD;
      HOLD: if (hold_cnt == '0) state_next = RUN;
      RUN: begin
        if (halt_hit) begin
          state_next  = DONE;
          status_next = ST_HALT;
        end else if (loop_hit) begin
          state_next  = DONE;
          status_next = ST_LOOP;
        end else if (time_hit) begin
          state_next  = DONE;
          status_next = ST_TIME;
        end
      end
      DONE: if (start) state_next = HOLD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_s) begin
      hold_cnt    <= '0;
      last_addr   <= '0;
      last_valid  <= 1'b0;
      rep         <= '0;
      status      <= ST_NONE;
      exit_code   <= '0;
      cycle_count <= '0;
      fetch_count <= '0;
      load_count  <= '0;
      store_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            hold_cnt    <= HOLD_W'(RESET_HOLD - 1);
            last_addr   <= '0;
            last_valid  <= 1'b0;
            rep         <= '0;
            status      <= ST_NONE;
            exit_code   <= '0;
            cycle_count <= '0;
            fetch_count <= '0;
            load_count  <= '0;
            store_count <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
        RUN: begin
          cycle_count <= cycle_next;
          if (in_mem_en)  fetch_count <= sat_inc(fetch_count);
          if (data_read)  load_count  <= sat_inc(load_count);
          if (data_write) store_count <= sat_inc(store_count);
          // The valid flag makes the first fetch of a run load the tracker even at address 0.
          if (in_mem_en) begin
            if (repeat_fetch) begin
              rep <= rep + 1'b1;
            end else begin
              last_addr  <= in_mem_addr;
              last_valid <= 1'b1;
              rep        <= '0;
            end
          end
          if (state_next == DONE) status <= status_next;
          if (halt_hit) exit_code <= data_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scc_run_monitor.sv
// tb/tb_scc_run_monitor.sv - directed vector bench for scc_run_monitor.
// dut_a uses default parameters; dut_b (MAX_CYCLES=4, STALL_LIMIT=3) shares stimulus for priority corners.
module tb_scc_run_monitor;

  logic        clk;
  logic        reset_s;
  logic        start;
  logic        in_mem_en;
  logic [31:0] in_mem_addr;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic        data_read;
  logic        data_write;

  logic        a_core_reset, a_running, a_done;
  logic [1:0]  a_status;
  logic [31:0] a_exit;
  logic [15:0] a_cycle, a_fetch, a_load, a_store;
  logic        b_core_reset, b_running, b_done;
  logic [1:0]  b_status;
  logic [31:0] b_exit;
  logic [15:0] b_cycle, b_fetch, b_load, b_store;

  int checks;
  int failures;

  scc_run_monitor dut_a (
    .clk(clk), .reset_s(reset_s), .start(start),
    .in_mem_en(in_mem_en), .in_mem_addr(in_mem_addr),
    .data_addr(data_addr), .data_out(data_out),
    .data_read(data_read), .data_write(data_write),
    .core_reset(a_core_reset), .running(a_running), .done(a_done),
    .status(a_status), .exit_code(a_exit), .cycle_count(a_cycle),
    .fetch_count(a_fetch), .load_count(a_load), .store_count(a_store)
  );

  scc_run_monitor #(.MAX_CYCLES(4), .STALL_LIMIT(3)) dut_b (
    .clk(clk), .reset_s(reset_s), .start(start),
    .in_mem_en(in_mem_en), .in_mem_addr(in_mem_addr),
    .data_addr(data_addr), .data_out(data_out),
    .data_read(data_read), .data_write(data_write),
    .core_reset(b_core_reset), .running(b_running), .done(b_done),
    .status(b_status), .exit_code(b_exit), .cycle_count(b_cycle),
    .fetch_count(b_fetch), .load_count(b_load), .store_count(b_store)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        fetch;
    logic [31:0] faddr;
    logic        rd;
    logic        wr;
    logic [31:0] daddr;
    logic [31:0] dout;
    logic        e_core_reset;
    logic        e_running;
    logic        e_done;
    logic [1:0]  e_status;
    logic [15:0] e_cycle;
    logic [15:0] e_fetch;
    logic [15:0] e_load;
    logic [15:0] e_store;
    logic [31:0] e_exit;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic st, input logic f, input logic [31:0] fa,
                              input logic rd, input logic wr, input logic [31:0] da,
                              input logic [31:0] dout, input logic cr, input logic rn,
                              input logic dn, input logic [1:0] stat, input logic [15:0] cyc,
                              input logic [15:0] fc, input logic [15:0] lc, input logic [15:0] sc,
                              input logic [31:0] ex);
    vec_t v;
    v.start = st; v.fetch = f; v.faddr = fa; v.rd = rd; v.wr = wr; v.daddr = da; v.dout = dout;
    v.e_core_reset = cr; v.e_running = rn; v.e_done = dn; v.e_status = stat;
    v.e_cycle = cyc; v.e_fetch = fc; v.e_load = lc; v.e_store = sc; v.e_exit = ex;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    start = 1'b0; in_mem_en = 1'b0; in_mem_addr = '0;
    data_addr = '0; data_out = '0; data_read = 1'b0; data_write = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    reset_s = 1'b0;
    step();
    step();
    reset_s = 1'b1;
  endtask

  // Start pulse, two HOLD cycles, then the first edge in RUN.
  task automatic go_run();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
  endtask

  function automatic logic [127:0] pack_a();
    return {27'd0, a_core_reset, a_running, a_done, a_status, a_cycle, a_fetch, a_load, a_store, a_exit};
  endfunction

  initial begin
    int n;
    checks = 0;
    failures = 0;
    reset_s = 1'b0;
    idle_bus();

    vecs[0]  = mk(1, 0, 32'h0,   0, 0, 32'h0,         32'h0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,   0, 0, 32'h0,         32'h0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 1, 32'h100, 1, 0, 32'h300,       32'h0,  0, 1, 0, 2'd0, 0, 0, 0, 0, 32'h0);
    vecs[3]  = mk(0, 1, 32'h100, 0, 0, 32'h0,         32'h0,  0, 1, 0, 2'd0, 1, 1, 0, 0, 32'h0);
    vecs[4]  = mk(0, 1, 32'h104, 1, 0, 32'h300,       32'h0,  0, 1, 0, 2'd0, 2, 2, 1, 0, 32'h0);
    vecs[5]  = mk(0, 1, 32'h108, 0, 1, 32'h200,       32'h55, 0, 1, 0, 2'd0, 3, 3, 1, 1, 32'h0);
    vecs[6]  = mk(0, 1, 32'h10C, 1, 0, 32'h300,       32'h0,  0, 1, 0, 2'd0, 4, 4, 2, 1, 32'h0);
    vecs[7]  = mk(0, 1, 32'h110, 0, 1, 32'hFFFF_FFFC, 32'h2A, 1, 0, 1, 2'd1, 5, 5, 2, 2, 32'h2A);
    vecs[8]  = mk(0, 1, 32'h114, 1, 1, 32'hFFFF_FFFC, 32'h99, 1, 0, 1, 2'd1, 5, 5, 2, 2, 32'h2A);
    vecs[9]  = mk(1, 0, 32'h0,   0, 0, 32'h0,         32'h0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 32'h0);
    vecs[10] = mk(0, 0, 32'h0,   0, 0, 32'h0,         32'h0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,   0, 0, 32'h0,         32'h0,  0, 1, 0, 2'd0, 0, 0, 0, 0, 32'h0);
    vecs[12] = mk(1, 1, 32'h400, 0, 0, 32'h0,         32'h0,  0, 1, 0, 2'd0, 1, 1, 0, 0, 32'h0);
    vecs[13] = mk(0, 1, 32'h404, 0, 0, 32'h0,         32'h0,  0, 1, 0, 2'd0, 2, 2, 0, 0, 32'h0);

    // Reset state
    step();
    step();
    check("reset_a", pack_a(), {27'd0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0});
    check("reset_b", {b_core_reset, b_running, b_done, b_status, b_cycle, b_exit},
          {1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 32'd0});
    reset_s = 1'b1;

    // Halt store on RUN cycle 5, then restart from DONE and ignore start in RUN
    for (int i = 0; i < 14; i++) begin
      start = vecs[i].start; in_mem_en = vecs[i].fetch; in_mem_addr = vecs[i].faddr;
      data_read = vecs[i].rd; data_write = vecs[i].wr;
      data_addr = vecs[i].daddr; data_out = vecs[i].dout;
      step();
      check($sformatf("vec%0d", i), pack_a(),
            {27'd0, vecs[i].e_core_reset, vecs[i].e_running, vecs[i].e_done, vecs[i].e_status,
             vecs[i].e_cycle, vecs[i].e_fetch, vecs[i].e_load, vecs[i].e_store, vecs[i].e_exit});
    end

    // Timeout after 29 RUN cycles, core_reset high exactly 2 cycles
    do_reset();
    start = 1'b1;
    step();
    check("t1_hold1", {a_core_reset, a_running}, {1'b1, 1'b0});
    start = 1'b0;
    step();
    check("t1_hold2", {a_core_reset, a_running}, {1'b1, 1'b0});
    step();
    check("t1_run", {a_core_reset, a_running}, {1'b0, 1'b1});
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      in_mem_en = 1'b1;
      in_mem_addr = 32'h1000 + 32'(4 * k);
      step();
      n = k;
      if (a_done) break;
    end
    idle_bus();
    check("t1_done", {a_done, a_status}, {1'b1, 2'd3});
    check("t1_counts", {a_cycle, a_fetch, a_exit}, {16'd29, 16'd29, 32'd0});
    check("t1_len", 128'(n), 128'd29);

    // Self-loop: 9th fetch of 0x10
    do_reset();
    go_run();
    n = 0;
    for (int k = 1; k <= 50; k++) begin
      in_mem_en = 1'b1;
      in_mem_addr = 32'h10;
      step();
      n = k;
      if (a_done) break;
    end
    idle_bus();
    check("t3_done", {a_done, a_status}, {1'b1, 2'd2});
    check("t3_counts", {a_cycle, a_fetch}, {16'd9, 16'd9});
    check("t3_len", 128'(n), 128'd9);

    // Halt store, self-loop and timeout in the same cycle -> halt wins
    do_reset();
    go_run();
    for (int k = 1; k <= 4; k++) begin
      in_mem_en = 1'b1;
      in_mem_addr = 32'h20;
      if (k == 4) begin
        data_write = 1'b1; data_addr = 32'hFFFF_FFFC; data_out = 32'h77;
      end
      step();
      if (k == 3) check("t4_not_yet", {b_done, b_running}, {1'b0, 1'b1});
    end
    idle_bus();
    check("t4_halt", {b_done, b_status, b_exit}, {1'b1, 2'd1, 32'h77});
    check("t4_counts", {b_cycle, b_fetch, b_store}, {16'd4, 16'd4, 16'd1});

    // Self-loop beats timeout
    go_run();
    check("t4_restart", {b_running, b_status, b_cycle, b_exit}, {1'b1, 2'd0, 16'd0, 32'd0});
    for (int k = 1; k <= 4; k++) begin
      in_mem_en = 1'b1;
      in_mem_addr = 32'h20;
      step();
    end
    idle_bus();
    check("t4_loop", {b_done, b_status, b_cycle, b_exit}, {1'b1, 2'd2, 16'd4, 32'd0});

    // Distinct fetches -> plain timeout at 4
    go_run();
    for (int k = 1; k <= 4; k++) begin
      in_mem_en = 1'b1;
      in_mem_addr = 32'h20 + 32'(4 * k);
      step();
    end
    idle_bus();
    check("t4_time", {b_done, b_status, b_cycle}, {1'b1, 2'd3, 16'd4});

    // Reset during RUN cycle 3 aborts the run
    do_reset();
    go_run();
    in_mem_en = 1'b1; in_mem_addr = 32'h40;
    step();
    in_mem_addr = 32'h44; data_read = 1'b1;
    step();
    check("t5_pre", {a_running, a_cycle, a_load}, {1'b1, 16'd2, 16'd1});
    reset_s = 1'b0;
    in_mem_addr = 32'h48;
    step();
    reset_s = 1'b1;
    idle_bus();
    check("t5_abort", pack_a(), {27'd0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0});
    step();
    step();
    check("t5_stay_idle", {a_core_reset, a_running, a_done}, {1'b1, 1'b0, 1'b0});
    go_run();
    check("t5_rerun", {a_core_reset, a_running, a_cycle}, {1'b0, 1'b1, 16'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
